// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   IF-stage branch predictor: a direct-mapped BTB plus a table of
//   CTR_BITS-wide saturating counters. The counter table is indexed
//   bimodally (MODE=0) or gshare-style (MODE=1, index XOR history).
//   Lookups are combinational from registered state. Updates arrive
//   from the resolution stage and commit on the clock edge when
//   upd_en && !freeze. Mispredict and correct_pc go to the hazard unit.
//
// Ports
//   CLK, nRST           clock (rising edge), async active-low reset
//   freeze              pipeline stall, blocks all state updates
//   lookup_pc           IF-stage PC
//   predict_taken       predicted taken
//   predict_target      predicted target (lookup_pc+4 when not taken)
//   btb_hit             valid tag match for lookup_pc
//   lookup_ghr          history snapshot carried down the pipeline
//   upd_en              a branch resolved this cycle
//   upd_pc/upd_ghr      PC and lookup_ghr of that branch
//   upd_taken/target    actual outcome and taken target
//   upd_pred_taken/target  prediction that was made for it
//   mispredict          resolution disagrees with prediction
//   correct_pc          fetch redirect address
//   stat_branches       committed updates (only with BPRED_STATS_EN)
//   stat_mispredicts    committed mispredicted updates (BPRED_STATS_EN)
//
// Build option: define BPRED_STATS_EN to add the saturating statistics
// counters and their output ports.

module branch_predict_unit #(
    parameter int IDX_W    = 4,
    parameter int CTR_BITS = 2,
    parameter int GHR_W    = 4,
    parameter int MODE     = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              freeze,
    input  logic [31:0]       lookup_pc,
    output logic              predict_taken,
    output logic [31:0]       predict_target,
    output logic              btb_hit,
    output logic [GHR_W-1:0]  lookup_ghr,
    input  logic              upd_en,
    input  logic [31:0]       upd_pc,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       correct_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [GHR_W-1:0]    ghr_q;

    logic [IDX_W-1:0] lk_idx, lk_cidx, up_idx, up_cidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic             commit;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];

    // gshare folds the (zero-extended) history into the counter index only;
    // the BTB is always indexed by PC.
    assign lk_cidx = (MODE == 1) ? (lk_idx ^ IDX_W'(ghr_q))   : lk_idx;
    assign up_cidx = (MODE == 1) ? (up_idx ^ IDX_W'(upd_ghr)) : up_idx;

    assign btb_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign predict_taken  = btb_hit && ctr_q[lk_cidx][CTR_BITS-1];
    assign predict_target = predict_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
    assign lookup_ghr     = ghr_q;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign commit = upd_en && !freeze;

    assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
            ghr_q <= '0;
        end else if (commit) begin
            if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                // A freshly allocated branch starts weakly taken rather than
                // inheriting whatever count the (possibly aliased) slot held.
                if (!up_hit)
                    ctr_q[up_cidx] <= CTR_WT;
                else if (ctr_q[up_cidx] != CTR_MAX)
                    ctr_q[up_cidx] <= ctr_q[up_cidx] + 1'b1;
            end else if (ctr_q[up_cidx] != '0) begin
                ctr_q[up_cidx] <= ctr_q[up_cidx] - 1'b1;
            end
            if (MODE == 1)
                ghr_q <= {ghr_q[GHR_W-2:0], upd_taken};
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (commit) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: one bimodal and one gshare instance share
// the same stimulus and are compared against a table-level reference model.

module tb_branch_predict_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        freeze;
    logic [31:0] lookup_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pt [2];
    logic [31:0] ptgt [2];
    logic        hit [2];
    logic [3:0]  lghr [2];
    logic        mp [2];
    logic [31:0] cpc [2];
`ifdef BPRED_STATS_EN
    logic [31:0] sb [2];
    logic [31:0] sm [2];
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    branch_predict_unit #(.IDX_W(4), .CTR_BITS(2), .GHR_W(4), .MODE(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .lookup_pc(lookup_pc),
        .predict_taken(pt[0]), .predict_target(ptgt[0]), .btb_hit(hit[0]),
        .lookup_ghr(lghr[0]), .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mp[0]), .correct_pc(cpc[0])
`ifdef BPRED_STATS_EN
        , .stat_branches(sb[0]), .stat_mispredicts(sm[0])
`endif
    );

    branch_predict_unit #(.IDX_W(4), .CTR_BITS(2), .GHR_W(4), .MODE(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .lookup_pc(lookup_pc),
        .predict_taken(pt[1]), .predict_target(ptgt[1]), .btb_hit(hit[1]),
        .lookup_ghr(lghr[1]), .upd_en(upd_en), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mp[1]), .correct_pc(cpc[1])
`ifdef BPRED_STATS_EN
        , .stat_branches(sb[1]), .stat_mispredicts(sm[1])
`endif
    );

    // Reference model: one BTB slot per index, integer counters 0..3.
    bit          m_valid [2][16];
    int unsigned m_tag   [2][16];
    logic [31:0] m_tgt   [2][16];
    int          m_ctr   [2][16];
    int          m_ghr   [2];
    longint      m_sb    [2];
    longint      m_sm    [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[m][i] = 0;
                m_tag[m][i]   = 0;
                m_tgt[m][i]   = 32'd0;
                m_ctr[m][i]   = 1;
            end
            m_ghr[m] = 0;
            m_sb[m]  = 0;
            m_sm[m]  = 0;
        end
    endtask

    function automatic bit m_hit(int m, logic [31:0] pc);
        int idx = int'(pc[5:2]);
        return m_valid[m][idx] && (m_tag[m][idx] == int'(pc[31:6]));
    endfunction

    function automatic int m_cidx(int m, logic [31:0] pc, int ghr);
        int idx = int'(pc[5:2]);
        return (m == 1) ? (idx ^ ghr) : idx;
    endfunction

    function automatic bit exp_mispredict();
        if (!upd_en) return 0;
        if (upd_taken != upd_pred_taken) return 1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic model_commit();
        if (!(upd_en && !freeze)) return;
        for (int m = 0; m < 2; m++) begin
            int  idx  = int'(upd_pc[5:2]);
            int  c    = m_cidx(m, upd_pc, int'(upd_ghr));
            bit  h    = m_hit(m, upd_pc);
            m_sb[m]++;
            if (exp_mispredict()) m_sm[m]++;
            if (upd_taken) begin
                m_ctr[m][c]   = h ? ((m_ctr[m][c] + 1 > 3) ? 3 : m_ctr[m][c] + 1) : 2;
                m_valid[m][idx] = 1;
                m_tag[m][idx]   = int'(upd_pc[31:6]);
                m_tgt[m][idx]   = upd_target;
            end else begin
                m_ctr[m][c] = (m_ctr[m][c] == 0) ? 0 : m_ctr[m][c] - 1;
            end
            if (m == 1) m_ghr[m] = ((m_ghr[m] << 1) | int'(upd_taken)) & 15;
        end
    endtask

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int  idx = int'(lookup_pc[5:2]);
            bit  h   = m_hit(m, lookup_pc);
            bit  tk  = h && (m_ctr[m][m_cidx(m, lookup_pc, m_ghr[m])] >= 2);
            logic [31:0] et = tk ? m_tgt[m][idx] : lookup_pc + 32'd4;
            bit  emp = exp_mispredict();
            chk($sformatf("m%0d btb_hit", m), {31'd0, hit[m]}, {31'd0, h});
            chk($sformatf("m%0d predict_taken", m), {31'd0, pt[m]}, {31'd0, tk});
            chk($sformatf("m%0d predict_target", m), ptgt[m], et);
            chk($sformatf("m%0d lookup_ghr", m), {28'd0, lghr[m]}, 32'(m_ghr[m]));
            chk($sformatf("m%0d mispredict", m), {31'd0, mp[m]}, {31'd0, emp});
            if (emp)
                chk($sformatf("m%0d correct_pc", m), cpc[m],
                    upd_taken ? upd_target : upd_pc + 32'd4);
`ifdef BPRED_STATS_EN
            chk($sformatf("m%0d stat_branches", m), sb[m], 32'(m_sb[m]));
            chk($sformatf("m%0d stat_mispredicts", m), sm[m], 32'(m_sm[m]));
`endif
        end
    endtask

    // Inputs are driven just after the falling edge; outputs are checked 1ns
    // later, then the model commits on the rising edge.
    task automatic step();
        #1 check_all();
        @(posedge CLK);
        model_commit();
        @(negedge CLK);
    endtask

    task automatic drive(bit en, logic [31:0] pc, logic [3:0] g, bit tk,
                         logic [31:0] tgt, bit ptk, logic [31:0] ptg, bit frz);
        upd_en = en; upd_pc = pc; upd_ghr = g; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptg; freeze = frz;
    endtask

    initial begin
        nRST = 1'b0;
        lookup_pc = 32'h40;
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        model_reset();
        #12;
        @(negedge CLK);
        nRST = 1'b1;

        // Reset state
        step();
        chk("reset predict_target", ptgt[0], 32'h44);

        // First taken update on a cold entry
        drive(1, 32'h40, 4'h0, 1, 32'h100, 0, 32'h44, 0);
        step();
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();
        chk("allocated predict_target", ptgt[0], 32'h100);

        // Saturation upward then downward
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40, 4'h0, 1, 32'h100, 1, 32'h100, 0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h40, 4'h0, 0, 32'h100, 1, 32'h100, 0);
            step();
        end
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();

        // Frozen update commits exactly once
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40, 4'h0, 1, 32'h100, 0, 32'h44, 1);
            step();
        end
        drive(1, 32'h40, 4'h0, 1, 32'h100, 0, 32'h44, 0);
        step();
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();

        // Aliasing: same index, different tag
        drive(1, 32'h40, 4'h0, 1, 32'h100, 1, 32'h100, 0);
        step();
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        lookup_pc = 32'h440;
        step();
        chk("alias predict_target", ptgt[0], 32'h444);

        // gshare indexing after two taken commits
        lookup_pc = 32'h40;
        drive(1, 32'h80, 4'h0, 1, 32'h200, 1, 32'h200, 0);
        step();
        drive(1, 32'h80, 4'h1, 1, 32'h200, 1, 32'h200, 0);
        step();
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();
        drive(1, 32'h40, 4'h0, 0, 32'h100, 1, 32'h100, 0);
        step();
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, tg;
            bit tk;
            lookup_pc = 32'h40 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 1)) * 32'h400;
            pc = 32'h40 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 1)) * 32'h400;
            tg = $urandom & 32'hFFFF_FFFC;
            tk = 1'($urandom_range(0, 1));
            drive($urandom_range(0, 3) != 0, pc, 4'($urandom_range(0, 15)), tk,
                  tg, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? tg : pc + 32'd4,
                  $urandom_range(0, 4) == 0);
            step();
        end

        // Asynchronous reset in the middle of an update cycle
        drive(1, 32'h40, 4'h0, 1, 32'h300, 0, 32'h44, 0);
        lookup_pc = 32'h40;
        #2 nRST = 1'b0;
        model_reset();
        #1 check_all();
        chk("async reset btb_hit", {31'd0, hit[0]}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 32'h0, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
